tt_bist_harness: RTL and testbench

Parametrised on-chip built-in self-test harness for a Tiny Tapeout user design. It does in silicon the job the cocotb testbench does off-chip: it drives a pseudo-random LFSR stimulus into a design-under-test (DUT) and compacts the DUT responses into a MISR signature. It then compares that signature against a golden value and reports pass/fail. It sits inside the `tt_um_*` top between the pad-level ports and the DUT, and supports a configurable bus width, run length and DUT response latency.

---
 rtl/tt_bist_harness.sv | 85 ++++++++
 tb/tb_tt_bist_harness.sv | 123 ++++++++++++
 2 files changed

// File: rtl/tt_bist_harness.sv
// tt_bist_harness: LFSR stimulus generator and MISR response compactor with golden-signature check
module tt_bist_harness #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] POLY = 'hB8,
  parameter logic [WIDTH-1:0] SEED = 'h01,
  parameter int RESP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] LO = 4'((1 << RESP_LAT) - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] lfsr, lfsr_nx, misr, misr_nx, misr_step;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_dec;
  logic [2:0] vp, vp_nx;
  logic [3:0] av;
  logic pass_r, pass_nx, issue, absorb, last;
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
    return x[0] ? (x >> 1) ^ POLY : x >> 1;
  endfunction
  assign issue = state == RUN && cnt != '0;
  assign cnt_dec = issue ? cnt - 1'b1 : cnt;
  // av[j] is set when the stimulus issued j edges ago has its response due now
  assign av = {vp, issue};
  assign absorb = state == RUN && av[RESP_LAT];
  assign misr_step = step(misr) ^ resp;
  assign last = absorb && (av & LO) == '0 && cnt_dec == '0;
  always_comb begin
    state_nx = state;
    lfsr_nx = lfsr;
    misr_nx = misr;
    cnt_nx = cnt;
    vp_nx = vp;
    pass_nx = pass_r;
    if (state == RUN) begin
      lfsr_nx = issue ? step(lfsr) : lfsr;
      cnt_nx = cnt_dec;
      vp_nx = {vp[1:0], issue};
      misr_nx = absorb ? misr_step : misr;
      state_nx = last ? DONE : RUN;
      pass_nx = last ? misr_step == golden : pass_r;
    end else if (start) begin
      lfsr_nx = SEED;
      misr_nx = '0;
      cnt_nx = num_cycles;
      vp_nx = '0;
      state_nx = num_cycles == '0 ? DONE : RUN;
      pass_nx = num_cycles == '0 && golden == '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lfsr <= SEED;
      misr <= '0;
      cnt <= '0;
      vp <= '0;
      pass_r <= 1'b0;
    end else if (ena) begin
      state <= state_nx;
      lfsr <= lfsr_nx;
      misr <= misr_nx;
      cnt <= cnt_nx;
      vp <= vp_nx;
      pass_r <= pass_nx;
    end
  end
  assign stim = issue ? lfsr : '0;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = pass_r;
  assign signature = misr;
endmodule

// File: tb/tb_tt_bist_harness.sv
// tb_tt_bist_harness: loopback (RESP_LAT=0) and registered-DUT (RESP_LAT=1) harnesses against a signature model
module tb_tt_bist_harness;
  logic clk = 1'b0, rst_n, ena, start;
  logic [7:0] num_cycles, golden0, golden1, key, resp1_q;
  logic [7:0] stim0, stim1, sig0, sig1;
  logic busy0, busy1, done0, done1, pass0, pass1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tt_bist_harness #(.RESP_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .num_cycles(num_cycles),
    .golden(golden0), .resp(stim0), .stim(stim0), .busy(busy0), .done(done0),
    .pass(pass0), .signature(sig0));
  tt_bist_harness #(.RESP_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .num_cycles(num_cycles),
    .golden(golden1), .resp(resp1_q), .stim(stim1), .busy(busy1), .done(done1),
    .pass(pass1), .signature(sig1));
  // one-register DUT, gated by ena like the harness
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) resp1_q <= '0;
    else if (ena) resp1_q <= stim1 ^ key;
  function automatic logic [7:0] step(input logic [7:0] x);
    return x[0] ? (x >> 1) ^ 8'hB8 : x >> 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int n, input int mode, input logic [7:0] k, input bit good0, input bit good1, input bit poke);
    logic [7:0] s, m0, m1, hold;
    logic [7:0] exp_stim[$], got[$];
    int act0 = 0, act1 = 0, tot0 = 0, tot1 = 0, nz0 = 0;
    s = 8'h01; m0 = '0; m1 = '0;
    for (int i = 0; i < n; i++) begin
      exp_stim.push_back(s);
      m0 = step(m0) ^ s;
      m1 = step(m1) ^ (s ^ k);
      s = step(s);
    end
    @(negedge clk);
    key = k; num_cycles = 8'(n); ena = 1'b1; start = 1'b1;
    golden0 = good0 ? m0 : m0 ^ 8'h01;
    golden1 = good1 ? m1 : m1 ^ 8'h80;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < 400 && !(done0 && done1); it++) begin
      ena = mode == 1 ? $urandom_range(3) != 0 : mode == 2 ? !(it == 1 || it == 2) : 1'b1;
      start = poke && it == 1;
      if (busy0) tot0++;
      if (busy1) tot1++;
      if (stim0 != '0) nz0++;
      if (ena && busy0) act0++;
      if (ena && busy1) act1++;
      if (ena && stim0 != '0) got.push_back(stim0);
      @(negedge clk);
    end
    start = 1'b0; ena = 1'b1;
    chk("finished", {30'd0, done0, done1}, 32'd3);
    chk("sig0", sig0, m0);
    chk("pass0", pass0, good0);
    chk("sig1", sig1, m1);
    chk("pass1", pass1, good1);
    chk("active0", act0, n);
    chk("active1", act1, n == 0 ? 0 : n + 1);
    if (mode != 1) begin
      chk("busy_len0", tot0, n + (mode == 2 ? 2 : 0));
      chk("busy_len1", tot1, n == 0 ? 0 : n + 1 + (mode == 2 ? 2 : 0));
      chk("stim_cycles", nz0, n + (mode == 2 ? 2 : 0));
    end
    chk("stim_count", got.size(), exp_stim.size());
    for (int i = 0; i < got.size() && i < exp_stim.size(); i++) chk("stim_seq", got[i], exp_stim[i]);
    hold = sig0;
    repeat (3) begin
      ena = 1'($urandom_range(1));
      @(negedge clk);
    end
    ena = 1'b1;
    chk("done_hold", {done0, pass0, sig0, stim0}, {1'b1, good0, hold, 8'h00});
  endtask
  initial begin
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; num_cycles = '0;
    golden0 = '0; golden1 = '0; key = '0;
    repeat (2) @(negedge clk);
    chk("reset0", {stim0, busy0, done0, pass0, sig0}, '0);
    chk("reset1", {stim1, busy1, done1, pass1, sig1}, '0);
    rst_n = 1'b1;
    run(3, 0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("loopback_sig", sig0, 8'h5C);
    chk("lat1_sig", sig1, 8'h5C);
    run(3, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("bad_golden_sig", sig0, 8'h5C);
    run(3, 0, 8'h00, 1'b0, 1'b1, 1'b0);
    run(3, 2, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("freeze_sig", sig0, 8'h5C);
    run(0, 0, 8'h00, 1'b1, 1'b1, 1'b0);
    run(0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    run(5, 0, 8'h3C, 1'b1, 1'b1, 1'b1);
    run(255, 0, 8'h5A, 1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(40, 1);
      run(n, 1, 8'($urandom), 1'($urandom), 1'($urandom), n >= 3 && $urandom_range(1) == 1);
    end
    @(negedge clk);
    num_cycles = 8'd20; ena = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun_busy", {busy0, busy1}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("abort0", {stim0, busy0, done0, pass0, sig0}, '0);
    chk("abort1", {stim1, busy1, done1, pass1, sig1}, '0);
    @(negedge clk);
    chk("abort_next", {stim0, busy0, done0, sig0, stim1, busy1, done1, sig1}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
